// File: rtl/btn_sched_pkg.sv
// Shared types and defaults for the button event scheduler.
// The FSM state enum, default sizes and the event-id width helper live here.
package btn_sched_pkg;

  typedef enum logic {IDLE, PRESENT} state_t;

  localparam int DIV_W_DEF        = 17;
  localparam int REPEAT_TICKS_DEF = 32;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/btn_chan.sv
// One button channel: 3-sample history on the shared tick, rise detect, and the
// optional hold/auto-repeat counter (built only with BTN_HOLD_REPEAT_EN).
module btn_chan
  import btn_sched_pkg::*;
#(
  parameter int REPEAT_TICKS = REPEAT_TICKS_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic tick_d,
  input  logic btn,
  output logic rise,
  output logic rep_req,
  output logic level
);

  logic [2:0] hist;

  // Newest sample enters at the top; hist[1] is the debounced level.
  always_ff @(posedge clk) begin
    if (!rst) begin
      hist <= '0;
    end else if (tick) begin
      hist <= {btn, hist[2:1]};
    end
  end

  assign level = hist[1];
  assign rise  = tick_d & hist[1] & ~hist[0];

`ifdef BTN_HOLD_REPEAT_EN
  localparam int HOLD_W = $clog2(REPEAT_TICKS + 1);

  logic [HOLD_W-1:0] hold_cnt;

  // The request fires on the tick that would bring the count to REPEAT_TICKS.
  assign rep_req = tick_d & hist[1] & ~rise &
                   (hold_cnt == HOLD_W'(REPEAT_TICKS - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      hold_cnt <= '0;
    end else if (rise || !hist[1] || rep_req) begin
      hold_cnt <= '0;
    end else if (tick_d) begin
      hold_cnt <= hold_cnt + 1'b1;
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = (REPEAT_TICKS > 0);
  assign rep_req    = 1'b0;
`endif

endmodule

// File: rtl/btn_event_scheduler.sv
// Shared push-button front end: common tick divider, per-button debounce and
// pending event, round-robin serialisation onto a valid/ready event port.
// Auto-repeat on long holds is enabled by defining BTN_HOLD_REPEAT_EN.
module btn_event_scheduler
  import btn_sched_pkg::*;
#(
  parameter  int N_BTN        = 4,
  parameter  int DIV_W        = DIV_W_DEF,
  parameter  int REPEAT_TICKS = REPEAT_TICKS_DEF,
  localparam int ID_W         = id_width(N_BTN)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_in,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [ID_W-1:0]  evt_id,
  output logic             evt_repeat,
  output logic             evt_drop,
  output logic [N_BTN-1:0] btn_level
);

  logic [DIV_W-1:0] div_cnt;
  logic             tick;
  logic             tick_d;

  logic [N_BTN-1:0] rise;
  logic [N_BTN-1:0] rep_req;
  logic [N_BTN-1:0] set_req;
  logic [N_BTN-1:0] clr_req;
  logic [N_BTN-1:0] drop_vec;
  logic [N_BTN-1:0] pending;

  state_t           state;
  state_t           state_next;
  logic             load;
  logic             accept;
  logic             sel_found;
  logic [ID_W-1:0]  sel_id;
  logic [ID_W-1:0]  cand;
  logic [ID_W-1:0]  rr;

  always_ff @(posedge clk) begin
    if (!rst) begin
      div_cnt <= '0;
      tick_d  <= 1'b0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
      tick_d  <= tick;
    end
  end

  assign tick = &div_cnt;

  for (genvar i = 0; i < N_BTN; i++) begin : g_chan
    btn_chan #(.REPEAT_TICKS(REPEAT_TICKS)) u_chan (
      .clk     (clk),
      .rst     (rst),
      .tick    (tick),
      .tick_d  (tick_d),
      .btn     (btn_in[i]),
      .rise    (rise[i]),
      .rep_req (rep_req[i]),
      .level   (btn_level[i])
    );
  end

  // A new request on a button whose event is still waiting is lost, unless
  // that very event is being accepted in the same cycle.
  always_comb begin
    set_req  = '0;
    clr_req  = '0;
    drop_vec = '0;
    for (int i = 0; i < N_BTN; i++) begin
      set_req[i]  = rise[i] | rep_req[i];
      clr_req[i]  = accept && (evt_id == ID_W'(i));
      drop_vec[i] = set_req[i] & pending[i] & ~clr_req[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pending  <= '0;
      evt_drop <= 1'b0;
    end else begin
      evt_drop <= |drop_vec;
      for (int i = 0; i < N_BTN; i++) begin
        if (set_req[i]) begin
          pending[i] <= 1'b1;
        end else if (clr_req[i]) begin
          pending[i] <= 1'b0;
        end
      end
    end
  end

  // First pending button at or above the round-robin pointer, wrapping.
  always_comb begin
    sel_found = 1'b0;
    sel_id    = '0;
    cand      = '0;
    for (int k = 0; k < N_BTN; k++) begin
      cand = ID_W'((int'(rr) + k) % N_BTN);
      if (!sel_found && pending[cand]) begin
        sel_found = 1'b1;
        sel_id    = cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (sel_found) begin
          load       = 1'b1;
          state_next = PRESENT;
        end
      end
      PRESENT: begin
        if (evt_ready) begin
          accept     = 1'b1;
          state_next = IDLE;
        end
      end
    endcase
  end

  assign evt_valid = (state == PRESENT);

  always_ff @(posedge clk) begin
    if (!rst) begin
      evt_id <= '0;
      rr     <= '0;
    end else begin
      if (load) begin
        evt_id <= sel_id;
      end
      if (accept) begin
        rr <= (evt_id == ID_W'(N_BTN - 1)) ? '0 : evt_id + 1'b1;
      end
    end
  end

`ifdef BTN_HOLD_REPEAT_EN
  logic [N_BTN-1:0] pend_rep;

  // A fresh press clears the repeat flag; a dropped request leaves it alone.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pend_rep   <= '0;
      evt_repeat <= 1'b0;
    end else begin
      for (int i = 0; i < N_BTN; i++) begin
        if (set_req[i] && !drop_vec[i]) begin
          pend_rep[i] <= rep_req[i];
        end
      end
      if (load) begin
        evt_repeat <= pend_rep[sel_id];
      end
    end
  end
`else
  assign evt_repeat = 1'b0;
`endif

endmodule
